// File: rtl/sn_pkg.sv
// Shared constants and types for the stochastic-number generator/accumulator pair.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sn_pkg;

  localparam int NUM_BIT = 8;
  localparam int DIM     = 3;
  localparam int SUM_W   = NUM_BIT + $clog2(DIM);
  localparam int LEN_W   = NUM_BIT + 1;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  typedef enum logic {
    SN_UNIPOLAR = 1'b0,
    SN_BIPOLAR  = 1'b1
  } sn_mode_e;

  typedef logic [NUM_BIT-1:0] cnt_t;
  typedef logic [SUM_W-1:0]   sum_t;
  typedef logic [LEN_W-1:0]   len_t;

  localparam cnt_t CNT_MAX = '1;
  localparam len_t LEN_MAX = len_t'(2 ** NUM_BIT);

  // SN multiplication: AND for unipolar encoding, XNOR for bipolar encoding.
  function automatic logic sn_product(input logic sn, input logic w, input logic mode);
    return (mode == logic'(SN_BIPOLAR)) ? ~(sn ^ w) : (sn & w);
  endfunction

endpackage

// File: rtl/sn_accumulator_if.sv
// Bundle between generator, accumulator and the neuron/activation consumer.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on the result side; the stream side has none.
interface sn_accumulator_if;
  import sn_pkg::*;

  // stream side, driven by the generator
  logic isgen;
  logic sn_bit [DIM-1:0];
  logic w_bit  [DIM-1:0];
  logic mode;

  // result side, toward the consumer
  logic valid;
  logic ready;
  cnt_t cnt [DIM-1:0];
  sum_t sum;
  len_t len;
  logic drop;

  modport master (
    input  isgen, sn_bit, w_bit, mode, ready,
    output valid, cnt, sum, len, drop
  );

  modport slave (
    output isgen, sn_bit, w_bit, mode, ready,
    input  valid, cnt, sum, len, drop
  );

endinterface

// File: rtl/sn_mult_cnt.sv
// One dimension: SN product gate feeding a saturating ones counter.
// Latency: count updates on the edge the product bit is sampled.
// Backpressure: none; load/en come from the window FSM.
module sn_mult_cnt
  import sn_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  input  logic mode,
  input  logic sn,
  input  logic w,
  output cnt_t cnt
);

  logic prod;

  assign prod = sn_product(sn, w, mode);

  // load restarts the count with the first product bit; en accumulates and holds at full scale
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= cnt_t'(prod);
    end else if (en && (cnt != CNT_MAX)) begin
      cnt <= cnt + cnt_t'(prod);
    end
  end

endmodule

// File: rtl/sn_accumulator.sv
// Counts SN products per dimension over a generate window and publishes counts, sum, length.
// Latency: results valid one cycle after the first isgen=0 sample that closes a window.
// Backpressure: none upstream; an unconsumed result is overwritten and flagged by a drop pulse.
module sn_accumulator
  import sn_pkg::*;
(
  input  logic             i_clk_sn_acc,
  input  logic             i_rst_n_sn_acc,
  sn_accumulator_if.master bus
);

  state_e state_q, state_n;
  logic   load, en, close;
  logic   mode_r, mode_sel;
  cnt_t   cnt_w [DIM-1:0];
  len_t   len_w;
  sum_t   sum_w;

  // first window cycle uses the live mode; the rest of the window uses the latched copy
  assign mode_sel = (state_q == IDLE) ? bus.mode : mode_r;

  for (genvar g = 0; g < DIM; g++) begin : g_dim
    sn_mult_cnt u_mult_cnt (
      .clk   (i_clk_sn_acc),
      .rst_n (i_rst_n_sn_acc),
      .load  (load),
      .en    (en),
      .mode  (mode_sel),
      .sn    (bus.sn_bit[g]),
      .w     (bus.w_bit[g]),
      .cnt   (cnt_w[g])
    );
  end

  // window state register
  always_ff @(posedge i_clk_sn_acc or negedge i_rst_n_sn_acc) begin
    if (!i_rst_n_sn_acc) state_q <= IDLE;
    else                 state_q <= state_n;
  end

  // window FSM: open on isgen rising, close on first isgen low
  always_comb begin
    state_n = state_q;
    load    = 1'b0;
    en      = 1'b0;
    close   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.isgen) begin
          load    = 1'b1;
          state_n = ACC;
        end
      end
      ACC: begin
        if (bus.isgen) begin
          en = 1'b1;
        end else begin
          close   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // window length and mode latch; length holds at a full window
  always_ff @(posedge i_clk_sn_acc or negedge i_rst_n_sn_acc) begin
    if (!i_rst_n_sn_acc) begin
      len_w  <= '0;
      mode_r <= 1'b0;
    end else if (load) begin
      len_w  <= len_t'(1);
      mode_r <= bus.mode;
    end else if (en && (len_w != LEN_MAX)) begin
      len_w  <= len_w + len_t'(1);
    end
  end

  // sum of the working counters, registered alongside them at window close
  always_comb begin
    sum_w = '0;
    for (int i = 0; i < DIM; i++) begin
      sum_w = sum_w + sum_t'(cnt_w[i]);
    end
  end

  // result registers and handshake; a new result always wins over a pending one
  always_ff @(posedge i_clk_sn_acc or negedge i_rst_n_sn_acc) begin
    if (!i_rst_n_sn_acc) begin
      bus.valid <= 1'b0;
      bus.drop  <= 1'b0;
      bus.sum   <= '0;
      bus.len   <= '0;
      for (int i = 0; i < DIM; i++) bus.cnt[i] <= '0;
    end else if (close) begin
      bus.valid <= 1'b1;
      bus.drop  <= bus.valid && !bus.ready;
      bus.sum   <= sum_w;
      bus.len   <= len_w;
      for (int i = 0; i < DIM; i++) bus.cnt[i] <= cnt_w[i];
    end else begin
      bus.drop <= 1'b0;
      if (bus.valid && bus.ready) bus.valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sn_accumulator.sv
// Directed bench for sn_accumulator: reset, unipolar/bipolar counting, saturation,
// overwrite/drop, same-edge handoff and mid-window reset.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_sn_accumulator;
  import sn_pkg::*;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  sn_accumulator_if bus ();

  sn_accumulator dut (
    .i_clk_sn_acc   (clk),
    .i_rst_n_sn_acc (rst_n),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bits(input logic s0, input logic s1, input logic s2,
                          input logic w0, input logic w1, input logic w2);
    bus.sn_bit[0] = s0; bus.sn_bit[1] = s1; bus.sn_bit[2] = s2;
    bus.w_bit[0]  = w0; bus.w_bit[1]  = w1; bus.w_bit[2]  = w2;
  endtask

  task automatic go_idle();
    bus.isgen = 1'b0;
    for (int i = 0; i < DIM; i++) begin
      bus.sn_bit[i] = 1'bx;
      bus.w_bit[i]  = 1'bx;
    end
  endtask

  task automatic test_reset();
    int exp_c [DIM];
    exp_c = '{0, 0, 0};
    rst_n = 1'b0; bus.ready = 1'b0; bus.mode = 1'b0; go_idle();
    repeat (3) tick();
    n_total++; if (bus.valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", bus.valid); else n_pass++;
    n_total++; if (bus.drop !== 1'b0) $display("FAIL reset_drop got %0b want 0", bus.drop); else n_pass++;
    n_total++; if (bus.sum !== sum_t'(0)) $display("FAIL reset_sum got %0d want 0", bus.sum); else n_pass++;
    n_total++; if (bus.len !== len_t'(0)) $display("FAIL reset_len got %0d want 0", bus.len); else n_pass++;
    for (int i = 0; i < DIM; i++) begin
      n_total++; if (bus.cnt[i] !== cnt_t'(exp_c[i])) $display("FAIL reset_cnt%0d got %0d want %0d", i, bus.cnt[i], exp_c[i]); else n_pass++;
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_unipolar_full();
    int exp_c [DIM];
    exp_c = '{255, 255, 255};
    bus.ready = 1'b1; bus.mode = 1'b0;
    set_bits(1, 1, 1, 1, 1, 1); bus.isgen = 1'b1;
    repeat (255) tick();
    n_total++; if (bus.valid !== 1'b0) $display("FAIL uni_full_early_valid got %0b want 0", bus.valid); else n_pass++;
    go_idle(); tick();
    n_total++; if (bus.valid !== 1'b1) $display("FAIL uni_full_valid got %0b want 1", bus.valid); else n_pass++;
    for (int i = 0; i < DIM; i++) begin
      n_total++; if (bus.cnt[i] !== cnt_t'(exp_c[i])) $display("FAIL uni_full_cnt%0d got %0d want %0d", i, bus.cnt[i], exp_c[i]); else n_pass++;
    end
    n_total++; if (bus.sum !== sum_t'(765)) $display("FAIL uni_full_sum got %0d want 765", bus.sum); else n_pass++;
    n_total++; if (bus.len !== len_t'(255)) $display("FAIL uni_full_len got %0d want 255", bus.len); else n_pass++;
    tick();
    n_total++; if (bus.valid !== 1'b0) $display("FAIL uni_full_pulse got %0b want 0", bus.valid); else n_pass++;
  endtask

  task automatic test_unipolar_pattern();
    int exp_c [DIM];
    exp_c = '{8, 0, 16};
    bus.ready = 1'b1; bus.mode = 1'b0; bus.isgen = 1'b1;
    for (int k = 0; k < 16; k++) begin
      set_bits((k % 2) == 0, 1, 1, 1, 0, 1);
      tick();
    end
    go_idle(); tick();
    n_total++; if (bus.valid !== 1'b1) $display("FAIL pattern_valid got %0b want 1", bus.valid); else n_pass++;
    for (int i = 0; i < DIM; i++) begin
      n_total++; if (bus.cnt[i] !== cnt_t'(exp_c[i])) $display("FAIL pattern_cnt%0d got %0d want %0d", i, bus.cnt[i], exp_c[i]); else n_pass++;
    end
    n_total++; if (bus.sum !== sum_t'(24)) $display("FAIL pattern_sum got %0d want 24", bus.sum); else n_pass++;
    n_total++; if (bus.len !== len_t'(16)) $display("FAIL pattern_len got %0d want 16", bus.len); else n_pass++;
    tick();
  endtask

  task automatic test_bipolar();
    // pass 0: sn=0,w=0 -> XNOR=1 each cycle; pass 1: sn=1,w=0 -> 0
    int exp_v [2];
    exp_v = '{10, 0};
    bus.ready = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      bus.isgen = 1'b1;
      for (int k = 0; k < 10; k++) begin
        bus.mode = (k == 0) ? 1'b1 : ((k < 4) ? 1'b1 : 1'b0);
        if (pass == 0) set_bits(0, 0, 0, 0, 0, 0);
        else           set_bits(1, 1, 1, 0, 0, 0);
        tick();
      end
      go_idle(); bus.mode = 1'b0; tick();
      n_total++; if (bus.valid !== 1'b1) $display("FAIL bipolar%0d_valid got %0b want 1", pass, bus.valid); else n_pass++;
      for (int i = 0; i < DIM; i++) begin
        n_total++; if (bus.cnt[i] !== cnt_t'(exp_v[pass])) $display("FAIL bipolar%0d_cnt%0d got %0d want %0d", pass, i, bus.cnt[i], exp_v[pass]); else n_pass++;
      end
      n_total++; if (bus.sum !== sum_t'(3 * exp_v[pass])) $display("FAIL bipolar%0d_sum got %0d want %0d", pass, bus.sum, 3 * exp_v[pass]); else n_pass++;
      n_total++; if (bus.len !== len_t'(10)) $display("FAIL bipolar%0d_len got %0d want 10", pass, bus.len); else n_pass++;
      tick();
    end
  endtask

  task automatic test_saturation();
    int exp_len [2];
    exp_len = '{256, 256};
    bus.ready = 1'b1; bus.mode = 1'b0;
    // pass 0: full window with forced-zero last bit; pass 1: overlong window of ones
    for (int pass = 0; pass < 2; pass++) begin
      bus.isgen = 1'b1;
      set_bits(1, 1, 1, 1, 1, 1);
      if (pass == 0) begin
        repeat (255) tick();
        set_bits(0, 0, 0, 1, 1, 1);
        tick();
      end else begin
        repeat (300) tick();
      end
      go_idle(); tick();
      for (int i = 0; i < DIM; i++) begin
        n_total++; if (bus.cnt[i] !== cnt_t'(255)) $display("FAIL sat%0d_cnt%0d got %0d want 255", pass, i, bus.cnt[i]); else n_pass++;
      end
      n_total++; if (bus.sum !== sum_t'(765)) $display("FAIL sat%0d_sum got %0d want 765", pass, bus.sum); else n_pass++;
      n_total++; if (bus.len !== len_t'(exp_len[pass])) $display("FAIL sat%0d_len got %0d want %0d", pass, bus.len, exp_len[pass]); else n_pass++;
      tick();
    end
  endtask

  task automatic test_overwrite();
    int exp_c [DIM];
    exp_c = '{4, 0, 4};
    bus.ready = 1'b0; bus.mode = 1'b0;
    bus.isgen = 1'b1; set_bits(1, 1, 1, 1, 1, 1);
    repeat (4) tick();
    go_idle(); tick();
    n_total++; if (bus.valid !== 1'b1) $display("FAIL ovw_first_valid got %0b want 1", bus.valid); else n_pass++;
    n_total++; if (bus.drop !== 1'b0) $display("FAIL ovw_first_drop got %0b want 0", bus.drop); else n_pass++;
    // second window starts on the cycle right after the close
    bus.isgen = 1'b1; set_bits(1, 0, 1, 1, 1, 1);
    repeat (4) tick();
    n_total++; if (bus.cnt[1] !== cnt_t'(4)) $display("FAIL ovw_held_cnt1 got %0d want 4", bus.cnt[1]); else n_pass++;
    n_total++; if (bus.sum !== sum_t'(12)) $display("FAIL ovw_held_sum got %0d want 12", bus.sum); else n_pass++;
    go_idle(); tick();
    n_total++; if (bus.valid !== 1'b1) $display("FAIL ovw_valid got %0b want 1", bus.valid); else n_pass++;
    n_total++; if (bus.drop !== 1'b1) $display("FAIL ovw_drop got %0b want 1", bus.drop); else n_pass++;
    for (int i = 0; i < DIM; i++) begin
      n_total++; if (bus.cnt[i] !== cnt_t'(exp_c[i])) $display("FAIL ovw_cnt%0d got %0d want %0d", i, bus.cnt[i], exp_c[i]); else n_pass++;
    end
    n_total++; if (bus.sum !== sum_t'(8)) $display("FAIL ovw_sum got %0d want 8", bus.sum); else n_pass++;
    n_total++; if (bus.len !== len_t'(4)) $display("FAIL ovw_len got %0d want 4", bus.len); else n_pass++;
    tick();
    n_total++; if (bus.drop !== 1'b0) $display("FAIL ovw_drop_width got %0b want 0", bus.drop); else n_pass++;
    n_total++; if (bus.valid !== 1'b1) $display("FAIL ovw_hold_valid got %0b want 1", bus.valid); else n_pass++;
    bus.ready = 1'b1; tick();
    n_total++; if (bus.valid !== 1'b0) $display("FAIL ovw_consume got %0b want 0", bus.valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int exp_c [DIM];
    exp_c = '{5, 5, 0};
    bus.ready = 1'b0; bus.mode = 1'b0;
    bus.isgen = 1'b1; set_bits(1, 1, 1, 1, 1, 1);
    repeat (2) tick();
    go_idle(); tick();
    bus.isgen = 1'b1; set_bits(1, 1, 1, 1, 1, 0);
    repeat (5) tick();
    // consumer accepts on the very edge the second window closes
    go_idle(); bus.ready = 1'b1; tick();
    n_total++; if (bus.valid !== 1'b1) $display("FAIL b2b_valid got %0b want 1", bus.valid); else n_pass++;
    n_total++; if (bus.drop !== 1'b0) $display("FAIL b2b_drop got %0b want 0", bus.drop); else n_pass++;
    for (int i = 0; i < DIM; i++) begin
      n_total++; if (bus.cnt[i] !== cnt_t'(exp_c[i])) $display("FAIL b2b_cnt%0d got %0d want %0d", i, bus.cnt[i], exp_c[i]); else n_pass++;
    end
    n_total++; if (bus.sum !== sum_t'(10)) $display("FAIL b2b_sum got %0d want 10", bus.sum); else n_pass++;
    n_total++; if (bus.len !== len_t'(5)) $display("FAIL b2b_len got %0d want 5", bus.len); else n_pass++;
    tick();
    n_total++; if (bus.valid !== 1'b0) $display("FAIL b2b_consume got %0b want 0", bus.valid); else n_pass++;
  endtask

  task automatic test_mid_reset();
    int exp_c [DIM];
    exp_c = '{3, 3, 3};
    bus.ready = 1'b0; bus.mode = 1'b0;
    bus.isgen = 1'b1; set_bits(1, 1, 1, 1, 1, 1);
    repeat (2) tick();
    go_idle(); tick();
    bus.isgen = 1'b1; set_bits(1, 1, 1, 1, 1, 1);
    repeat (50) tick();
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (bus.valid !== 1'b0) $display("FAIL mrst_valid got %0b want 0", bus.valid); else n_pass++;
    n_total++; if (bus.cnt[0] !== cnt_t'(0)) $display("FAIL mrst_cnt0 got %0d want 0", bus.cnt[0]); else n_pass++;
    n_total++; if (bus.sum !== sum_t'(0)) $display("FAIL mrst_sum got %0d want 0", bus.sum); else n_pass++;
    n_total++; if (bus.len !== len_t'(0)) $display("FAIL mrst_len got %0d want 0", bus.len); else n_pass++;
    go_idle();
    #3 rst_n = 1'b1;
    tick();
    bus.ready = 1'b1; bus.isgen = 1'b1; set_bits(1, 1, 1, 1, 1, 1);
    repeat (3) tick();
    go_idle(); tick();
    n_total++; if (bus.valid !== 1'b1) $display("FAIL mrst_after_valid got %0b want 1", bus.valid); else n_pass++;
    for (int i = 0; i < DIM; i++) begin
      n_total++; if (bus.cnt[i] !== cnt_t'(exp_c[i])) $display("FAIL mrst_after_cnt%0d got %0d want %0d", i, bus.cnt[i], exp_c[i]); else n_pass++;
    end
    n_total++; if (bus.sum !== sum_t'(9)) $display("FAIL mrst_after_sum got %0d want 9", bus.sum); else n_pass++;
    n_total++; if (bus.len !== len_t'(3)) $display("FAIL mrst_after_len got %0d want 3", bus.len); else n_pass++;
    tick();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_unipolar_full();
    test_unipolar_pattern();
    test_bipolar();
    test_saturation();
    test_overwrite();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
